edge_detector: RTL and testbench



---
 rtl/edge_detector_pkg.sv | 14 +
 rtl/edge_detector_sync_ff.sv | 24 ++
 rtl/edge_detector.sv | 70 +++++++
 tb/tb_edge_detector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_detector_pkg.sv
// Shared constants for the edge detector and its synchroniser.
// Polarity selectors, the default chain depth and the priming target helper.
package edge_detector_pkg;

    localparam int EDGE_RISE           = 0;
    localparam int EDGE_FALL           = 1;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Edges after reset release before the chain and history flop hold real samples.
    function automatic int prime_count(input int stages);
        return stages + 1;
    endfunction

endpackage

// File: rtl/edge_detector_sync_ff.sv
// Metastability synchroniser: a plain flop chain with asynchronous clear.
// The last stage is the only output that downstream logic may trust.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Turns a level change on an asynchronous line into a one-cycle strobe.
// Output stays quiet until the synchroniser and history flop are primed after reset.
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int FALL_EDGE   = EDGE_RISE,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic sig,
    output logic edge_sig
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(prime_count(SYNC_STAGES));
    localparam logic [CNT_W-1:0] PRIME_PRE = CNT_W'(prime_count(SYNC_STAGES) - 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("edge_detector: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic             s;
    logic             prev;
    logic             detect;
    logic             primed;
    logic [CNT_W-1:0] prime_cnt;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(sys_clk),
        .rst(rst),
        .d  (sig),
        .q  (s)
    );

    always_comb begin
        detect = 1'b0;
        if (FALL_EDGE == EDGE_FALL) begin
            detect = ~s & prev;
        end else begin
            detect = s & ~prev;
        end
    end

    // Saturating count of edges since reset release; primed latches high at saturation.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (prime_cnt != PRIME_CNT) begin
            prime_cnt <= prime_cnt + 1'b1;
            primed    <= (prime_cnt == PRIME_PRE);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            prev     <= 1'b0;
            edge_sig <= 1'b0;
        end else begin
            prev     <= s;
            edge_sig <= detect & primed;
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Bench for edge_detector: three instances (rise/2, fall/2, rise/3) share sig and rst,
// checked every cycle against a sample-history model plus directed pulse counts.
module tb_edge_detector;
    import edge_detector_pkg::*;

    logic sys_clk;
    logic rst;
    logic sig;
    logic edge_rise2;
    logic edge_fall2;
    logic edge_rise3;

    int vectors    = 0;
    int miscompares = 0;

    logic hist[$];
    string names[3] = '{"rise2", "fall2", "rise3"};
    int pulses[3];
    int exp_pulses[3];
    logic [2:0] last_obs;
    logic [2:0] last_exp;

    edge_detector #(.FALL_EDGE(EDGE_RISE), .SYNC_STAGES(2)) dut_rise2 (
        .sys_clk(sys_clk), .rst(rst), .sig(sig), .edge_sig(edge_rise2)
    );
    edge_detector #(.FALL_EDGE(EDGE_FALL), .SYNC_STAGES(2)) dut_fall2 (
        .sys_clk(sys_clk), .rst(rst), .sig(sig), .edge_sig(edge_fall2)
    );
    edge_detector #(.FALL_EDGE(EDGE_RISE), .SYNC_STAGES(3)) dut_rise3 (
        .sys_clk(sys_clk), .rst(rst), .sig(sig), .edge_sig(edge_rise3)
    );

    // 83-unit period; rising edges at 42 + 83n, falling edges at 83n.
    initial begin
        sys_clk = 1'b0;
        forever begin
            #42 sys_clk = 1'b1;
            #41 sys_clk = 1'b0;
        end
    end

    // Reference history: the level of sig seen at each clock edge since the last reset.
    always @(posedge sys_clk or posedge rst) begin
        if (rst) hist.delete();
        else     hist.push_back(sig);
    end

    // Pulse after edge k is owed when k >= n+2 and the samples taken at edges
    // k-n and k-n-1 differ in the wanted direction.
    function automatic logic model_edge(input logic rise, input int n);
        int k;
        logic cur;
        logic old;
        k = hist.size();
        if (k < n + 2) return 1'b0;
        cur = hist[k-n-1];
        old = hist[k-n-2];
        return rise ? (cur & ~old) : (~cur & old);
    endfunction

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin
            pulses[d]     = 0;
            exp_pulses[d] = 0;
        end
    endtask

    task automatic check_output(input int n);
        logic [2:0] obs;
        logic [2:0] expv;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            obs  = {edge_rise3, edge_fall2, edge_rise2};
            expv = {model_edge(1'b1, 3), model_edge(1'b0, 2), model_edge(1'b1, 2)};
            for (int d = 0; d < 3; d++) begin
                vectors++;
                assert (obs[d] === expv[d]) else begin
                    miscompares++;
                    $error("[TB] FAIL %s t=%0t observed %b expected %b", names[d], $time, obs[d], expv[d]);
                end
                if (obs[d] === 1'b1 && last_obs[d] !== 1'b1) pulses[d]++;
                if (expv[d] && !last_exp[d]) exp_pulses[d]++;
            end
            last_obs = obs;
            last_exp = expv;
        end
    endtask

    task automatic check_count(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            #($urandom_range(1, 30));
            if ($urandom_range(0, 2) == 0) sig = ~sig;
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        bit seen;
        last_obs = '0;
        last_exp = '0;
        clear_counts();
        rst = 1'b0;
        sig = 1'b0;
        #10 rst = 1'b1;
        #1  rst = 1'b0;

        // Basic edges: rise at 1000, held three periods, then dropped.
        fork
            begin
                #989 sig = 1'b1;
                #249 sig = 1'b0;
            end
            check_output(25);
        join
        check_count("basic_rise2_pulses", pulses[0], 1);
        check_count("basic_fall2_pulses", pulses[1], 1);
        check_count("basic_rise3_pulses", pulses[2], 1);

        // Reset while sig is high: no rising pulse may follow, the later drop is a real fall.
        fork
            begin
                @(negedge sys_clk);
                #10 sig = 1'b1;
            end
            check_output(8);
        join
        clear_counts();
        fork
            begin
                @(negedge sys_clk);
                #20 rst = 1'b1;
                #1  rst = 1'b0;
                #(6 * 83) sig = 1'b0;
            end
            check_output(14);
        join
        check_count("rsthigh_rise2_pulses", pulses[0], 0);
        check_count("rsthigh_rise3_pulses", pulses[2], 0);
        check_count("rsthigh_fall2_pulses", pulses[1], 1);

        // Toggling every 349 with short resets 20 before toggles 7 and 15 (both falls).
        clear_counts();
        fork
            begin
                @(negedge sys_clk);
                for (int i = 0; i < 20; i++) begin
                    if (i == 7 || i == 15) begin
                        #329 rst = 1'b1;
                        #1   rst = 1'b0;
                        #19  sig = ~sig;
                    end else begin
                        #((i == 0) ? 50 : 349) sig = ~sig;
                    end
                end
            end
            check_output(90);
        join
        check_count("toggle_rise2_pulses", pulses[0], 10);
        check_count("toggle_rise2_vs_model", pulses[0], exp_pulses[0]);
        check_count("toggle_fall2_vs_model", pulses[1], exp_pulses[1]);
        check_count("toggle_rise3_vs_model", pulses[2], exp_pulses[2]);

        // Reset mid-pulse: the strobe must vanish at once and nothing follows on a steady level.
        check_output(4);
        @(negedge sys_clk);
        #10 sig = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            check_output(1);
            if (edge_rise2 === 1'b1) seen = 1'b1;
        end
        check_count("midpulse_seen", int'(seen), 1);
        #10 rst = 1'b1;
        #1;
        vectors++;
        assert (edge_rise2 === 1'b0) else begin
            miscompares++;
            $error("[TB] FAIL midpulse_drop observed %b expected 0", edge_rise2);
        end
        rst = 1'b0;
        clear_counts();
        check_output(10);
        check_count("midpulse_after_pulses", pulses[0], 0);

        // Random phase and level activity with occasional resets.
        clear_counts();
        fork
            apply_stimulus_random(200);
            check_output(202);
        join
        check_count("random_rise2_pulses", pulses[0], exp_pulses[0]);
        check_count("random_fall2_pulses", pulses[1], exp_pulses[1]);
        check_count("random_rise3_pulses", pulses[2], exp_pulses[2]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
